// File: rtl/count_game_pkg.sv
// Shared types and helpers for the counting-game round controller.
package count_game_pkg;

  localparam int TARGET_W  = 7;
  localparam int MAX_COUNT = 99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_t;

  // The generator spans 0..127; anything past 99 is folded back into range.
  function automatic logic [TARGET_W-1:0] fold7(input logic [TARGET_W-1:0] r);
    return (r < TARGET_W'(100)) ? r : r - TARGET_W'(100);
  endfunction

endpackage

// File: rtl/count_game_ctrl_sec_tick.sv
// Seconds divider: emits a one-cycle tick each time the enabled counter wraps.
module sec_tick #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  assign tick = en & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr || !en || tick) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/count_game_ctrl.sv
// Round controller: captures the target on start release, counts presses
// against a per-second countdown and resolves the round as win or lose.
module count_game_ctrl
  import count_game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TIME_LIMIT    = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                st,
  input  logic [TARGET_W-1:0] rand_val,
  input  logic                btn,
  input  logic                ok,
  output logic [TARGET_W-1:0] target,
  output logic [TARGET_W-1:0] count,
  output logic [TARGET_W-1:0] time_left,
  output logic                busy,
  output logic                win,
  output logic                lose
);

  localparam logic [TARGET_W-1:0] LIMIT = TARGET_W'(TIME_LIMIT);
  localparam logic [TARGET_W-1:0] CMAX  = TARGET_W'(MAX_COUNT);

  state_t              state, state_nx;
  logic [TARGET_W-1:0] target_nx, count_nx, tl_nx;
  logic                st_s1, st_s2, st_d;
  logic                fall, tick;

  // st is asynchronous: two flops of synchronisation, then edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_s1 <= 1'b0;
      st_s2 <= 1'b0;
      st_d  <= 1'b0;
    end else begin
      st_s1 <= st;
      st_s2 <= st_s1;
      st_d  <= st_s2;
    end
  end

  assign fall = st_d & ~st_s2;

  sec_tick #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_sec_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == RUN),
    .clr   (fall),
    .tick  (tick)
  );

  always_comb begin
    state_nx  = state;
    target_nx = target;
    count_nx  = count;
    tl_nx     = time_left;
    if (fall) begin
      state_nx  = RUN;
      target_nx = fold7(rand_val);
      count_nx  = '0;
      tl_nx     = LIMIT;
    end else if (state == RUN) begin
      if (tick) tl_nx = time_left - TARGET_W'(1);
      // ok outranks expiry and btn; the compare sees the registered count.
      if (ok)
        state_nx = (count == target) ? WIN : LOSE;
      else if (tick && time_left == TARGET_W'(1))
        state_nx = LOSE;
      else if (btn && count < CMAX)
        count_nx = count + TARGET_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      target    <= '0;
      count     <= '0;
      time_left <= '0;
      busy      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      state     <= state_nx;
      target    <= target_nx;
      count     <= count_nx;
      time_left <= tl_nx;
      busy      <= (state_nx == RUN);
      win       <= (state_nx == WIN);
      lose      <= (state_nx == LOSE);
    end
  end

endmodule

// File: tb/tb_count_game_ctrl.sv
// Directed bench: a 3-second round drives the timing checks, and a 30-second
// round on the same stimulus gives room for long press sequences.
module tb_count_game_ctrl;

  logic       clk, rst_n, st, btn, ok;
  logic [6:0] rand_val;
  logic [6:0] s_target, s_count, s_time_left, l_target, l_count, l_time_left;
  logic       s_busy, s_win, s_lose, l_busy, l_win, l_lose;
  int         checks = 0;
  int         errors = 0;

  count_game_ctrl #(.TICKS_PER_SEC(4), .TIME_LIMIT(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .st(st), .rand_val(rand_val), .btn(btn), .ok(ok),
    .target(s_target), .count(s_count), .time_left(s_time_left),
    .busy(s_busy), .win(s_win), .lose(s_lose)
  );

  count_game_ctrl #(.TICKS_PER_SEC(4), .TIME_LIMIT(30)) dut_l (
    .clk(clk), .rst_n(rst_n), .st(st), .rand_val(rand_val), .btn(btn), .ok(ok),
    .target(l_target), .count(l_count), .time_left(l_time_left),
    .busy(l_busy), .win(l_win), .lose(l_lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Roll with st high, release just after an edge; RUN appears on the 3rd edge.
  task automatic start(input logic [6:0] rv);
    rand_val = rv;
    st = 1'b1;
    repeat (5) step();
    st = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; st = 1'b0; btn = 1'b0; ok = 1'b0; rand_val = 7'd0;
    repeat (2) step();
    checks++; if ({s_target, s_count, s_time_left, s_busy, s_win, s_lose} !== 24'd0) begin errors++; $display("FAIL reset_s: got %h expected 0", {s_target, s_count, s_time_left, s_busy, s_win, s_lose}); end
    checks++; if ({l_target, l_count, l_time_left, l_busy, l_win, l_lose} !== 24'd0) begin errors++; $display("FAIL reset_l: got %h expected 0", {l_target, l_count, l_time_left, l_busy, l_win, l_lose}); end
    rst_n = 1'b1;
    repeat (2) step();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b expected 0", s_busy); end
  endtask

  task automatic test_start();
    rand_val = 7'd37;
    st = 1'b1;
    repeat (5) step();
    st = 1'b0;
    repeat (2) step();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL start_early: busy %b expected 0", s_busy); end
    step();
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL start_busy: busy %b expected 1", s_busy); end
    checks++; if (s_target !== 7'd37) begin errors++; $display("FAIL start_target: got %0d expected 37", s_target); end
    checks++; if (s_time_left !== 7'd3) begin errors++; $display("FAIL start_time: got %0d expected 3", s_time_left); end
    checks++; if (l_time_left !== 7'd30) begin errors++; $display("FAIL start_time_l: got %0d expected 30", l_time_left); end
    checks++; if (s_count !== 7'd0) begin errors++; $display("FAIL start_count: got %0d expected 0", s_count); end
  endtask

  task automatic test_fold();
    logic [6:0] fin [4];
    logic [6:0] fexp [4];
    fin  = '{7'd99, 7'd100, 7'd127, 7'd0};
    fexp = '{7'd99, 7'd0, 7'd27, 7'd0};
    for (int i = 0; i < 4; i++) begin
      start(fin[i]);
      checks++; if (s_target !== fexp[i]) begin errors++; $display("FAIL fold_%0d: got %0d expected %0d", fin[i], s_target, fexp[i]); end
    end
  endtask

  task automatic test_win();
    start(7'd112);
    btn = 1'b1; repeat (12) step(); btn = 1'b0;
    checks++; if (l_target !== 7'd12) begin errors++; $display("FAIL win_target: got %0d expected 12", l_target); end
    checks++; if (l_count !== 7'd12) begin errors++; $display("FAIL win_count: got %0d expected 12", l_count); end
    ok = 1'b1; step(); ok = 1'b0;
    checks++; if ({l_win, l_lose, l_busy} !== 3'b100) begin errors++; $display("FAIL win_flags: got %b expected 100", {l_win, l_lose, l_busy}); end
    btn = 1'b1; repeat (2) step(); btn = 1'b0;
    checks++; if (l_count !== 7'd12 || l_win !== 1'b1) begin errors++; $display("FAIL win_hold: count %0d win %b expected 12 1", l_count, l_win); end
  endtask

  task automatic test_lose_compare();
    start(7'd5);
    btn = 1'b1; repeat (4) step(); btn = 1'b0;
    checks++; if (s_count !== 7'd4) begin errors++; $display("FAIL lose_cmp_count: got %0d expected 4", s_count); end
    ok = 1'b1; step(); ok = 1'b0;
    checks++; if ({s_win, s_lose, s_busy} !== 3'b010) begin errors++; $display("FAIL lose_cmp_flags: got %b expected 010", {s_win, s_lose, s_busy}); end
  endtask

  task automatic test_timeout();
    start(7'd9);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k % 4 == 0) begin
        checks++; if (s_time_left !== 7'(3 - k / 4)) begin errors++; $display("FAIL timeout_tl_k%0d: got %0d expected %0d", k, s_time_left, 3 - k / 4); end
      end
      if (k == 11) begin
        checks++; if ({s_busy, s_lose} !== 2'b10) begin errors++; $display("FAIL timeout_early: busy/lose %b expected 10", {s_busy, s_lose}); end
      end
    end
    checks++; if ({s_busy, s_win, s_lose} !== 3'b001) begin errors++; $display("FAIL timeout_lose: got %b expected 001", {s_busy, s_win, s_lose}); end
  endtask

  task automatic test_saturation();
    start(7'd120);
    btn = 1'b1; repeat (105) step(); btn = 1'b0;
    checks++; if (l_count !== 7'd99) begin errors++; $display("FAIL sat_count: got %0d expected 99", l_count); end
    checks++; if (l_busy !== 1'b1) begin errors++; $display("FAIL sat_busy: got %b expected 1", l_busy); end
  endtask

  task automatic test_same_cycle();
    start(7'd0);
    repeat (11) step();
    checks++; if (s_time_left !== 7'd1) begin errors++; $display("FAIL expiry_pre_tl: got %0d expected 1", s_time_left); end
    ok = 1'b1; step(); ok = 1'b0;
    checks++; if ({s_win, s_lose} !== 2'b10) begin errors++; $display("FAIL ok_expiry_flags: got %b expected 10", {s_win, s_lose}); end
    checks++; if (s_time_left !== 7'd0) begin errors++; $display("FAIL ok_expiry_tl: got %0d expected 0", s_time_left); end
    // btn+ok: compare must use the pre-increment count
    start(7'd3);
    btn = 1'b1; repeat (3) step(); ok = 1'b1; step(); btn = 1'b0; ok = 1'b0;
    checks++; if ({l_win, l_count} !== {1'b1, 7'd3}) begin errors++; $display("FAIL btn_ok_win: win %b count %0d expected 1 3", l_win, l_count); end
    start(7'd3);
    btn = 1'b1; repeat (2) step(); ok = 1'b1; step(); btn = 1'b0; ok = 1'b0;
    checks++; if ({l_lose, l_count} !== {1'b1, 7'd2}) begin errors++; $display("FAIL btn_ok_lose: lose %b count %0d expected 1 2", l_lose, l_count); end
  endtask

  task automatic test_back_to_back();
    logic flagged;
    start(7'd5);
    btn = 1'b1; repeat (2) step(); btn = 1'b0;
    flagged = 1'b0;
    rand_val = 7'd64;
    st = 1'b1;
    repeat (3) begin step(); flagged |= s_win | s_lose | l_win | l_lose; end
    st = 1'b0;
    repeat (3) begin step(); flagged |= s_win | s_lose | l_win | l_lose; end
    checks++; if (flagged !== 1'b0) begin errors++; $display("FAIL abort_flag: got %b expected 0", flagged); end
    checks++; if ({l_target, l_count, l_busy} !== {7'd64, 7'd0, 1'b1}) begin errors++; $display("FAIL abort_round: target %0d count %0d busy %b expected 64 0 1", l_target, l_count, l_busy); end
    checks++; if (s_target !== 7'd64) begin errors++; $display("FAIL abort_target_s: got %0d expected 64", s_target); end
  endtask

  task automatic test_reset_mid_run();
    start(7'd50);
    btn = 1'b1; repeat (3) step(); btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({s_target, s_count, s_time_left, s_busy, s_win, s_lose} !== 24'd0) begin errors++; $display("FAIL async_reset_s: got %h expected 0", {s_target, s_count, s_time_left, s_busy, s_win, s_lose}); end
    checks++; if ({l_target, l_count, l_time_left, l_busy, l_win, l_lose} !== 24'd0) begin errors++; $display("FAIL async_reset_l: got %h expected 0", {l_target, l_count, l_time_left, l_busy, l_win, l_lose}); end
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_start();
    test_fold();
    test_win();
    test_lose_compare();
    test_timeout();
    test_saturation();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
